// File: rtl/feedback_accumulator.sv
// Multi-channel signed feedback accumulator with optional leak, saturate/wrap arithmetic,
// global clear, sticky per-channel overflow and a registered valid/ready output stage.
module feedback_accumulator #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned SATURATE   = 1,
    parameter int unsigned LEAK_SHIFT = 0,
    localparam int unsigned CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     system1000,
    input  logic                     system1000_rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CW-1:0]            in_chan,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW-1:0]            out_chan,
    output logic signed [DATA_W-1:0] out_data,
    output logic [CHANNELS-1:0]      overflow
);

    localparam int unsigned EW = DATA_W + 2;
    localparam logic signed [EW-1:0] MaxV = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [EW-1:0] MinV = {3'b111, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] acc_q [CHANNELS];

    logic                     accept;
    logic                     chan_ok;
    logic signed [DATA_W-1:0] cur;
    logic signed [EW-1:0]     cur_x;
    logic signed [EW-1:0]     leak_x;
    logic signed [EW-1:0]     sum;
    logic                     ovf;
    logic signed [DATA_W-1:0] res;

    assign in_ready = !system1000_rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        chan_ok = 1'b0;
        cur     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_chan == CW'(i)) begin
                chan_ok = 1'b1;
                cur     = acc_q[i];
            end
        end
        // A same-cycle clear means the sample lands on a zeroed accumulator.
        if (clear) begin
            cur = '0;
        end
        cur_x  = {{2{cur[DATA_W-1]}}, cur};
        leak_x = (LEAK_SHIFT == 0) ? '0 : (cur_x >>> LEAK_SHIFT);
        sum    = cur_x - leak_x + {{2{in_data[DATA_W-1]}}, in_data};
        ovf    = (sum > MaxV) || (sum < MinV);
        res    = sum[DATA_W-1:0];
        if (ovf && (SATURATE != 0)) begin
            res = sum[EW-1] ? MinV[DATA_W-1:0] : MaxV[DATA_W-1:0];
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
            overflow  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else begin
            if (clear) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    acc_q[i] <= '0;
                end
                overflow <= '0;
            end
            if (accept && chan_ok) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (in_chan == CW'(i)) begin
                        acc_q[i]    <= res;
                        overflow[i] <= ovf | (overflow[i] & !clear);
                    end
                end
                out_valid <= 1'b1;
                out_data  <= res;
                out_chan  <= in_chan;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
